instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/nrisc_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 77 +++++++
 rtl/instr_fetch_queue.sv | 117 +++++++++++
 tb/tb_instr_fetch_queue.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nrisc_pkg.sv
// Shared widths and fetch FSM state type for the nrisc front end.
package nrisc_pkg;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DROP
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction byte FIFO with a registered head output and single-cycle flush.
module fetch_fifo
  import nrisc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WORD_W-1:0]      push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WORD_W-1:0]      head_data,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_n;
  logic [WORD_W-1:0] head_q;
  logic [WORD_W-1:0] head_n;

  always_comb begin
    count_n = count_q;
    if (flush) begin
      count_n = '0;
    end else begin
      count_n = count_q + CW'(push) - CW'(pop);
    end
  end

  // Head register is preloaded with whatever will sit at rd_ptr after this edge.
  always_comb begin
    head_n = head_q;
    if (!flush) begin
      if (pop) begin
        head_n = (count_q > CW'(1)) ? mem[rd_ptr + PW'(1)] : push_data;
      end else if (count_q == '0 && push) begin
        head_n = push_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      count_q <= count_n;
      head_q  <= head_n;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data  = head_q;
  assign head_valid = (count_q != '0);
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: one-outstanding-request fetch FSM feeding fetch_fifo.
// Optional FETCH_BYPASS_EN forwards ack data straight to the core when the queue is empty.
module instr_fetch_queue
  import nrisc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt,
  input  logic              instr_take,
  output logic [WORD_W-1:0] memInstr,
  output logic              instr_valid,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_data
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e      state_q;
  fetch_state_e      state_n;
  logic [ADDR_W-1:0] fetch_addr_q;
  logic [ADDR_W-1:0] fetch_addr_n;
  logic [ADDR_W-1:0] req_addr_q;
  logic [ADDR_W-1:0] req_addr_n;
  logic              ack_push;

  logic              fifo_push;
  logic              fifo_pop;
  logic [WORD_W-1:0] fifo_head;
  logic              fifo_valid;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;

  assign fifo_full = (fifo_count == CW'(DEPTH));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      fetch_addr_q <= '0;
      req_addr_q   <= '0;
    end else begin
      state_q      <= state_n;
      fetch_addr_q <= fetch_addr_n;
      req_addr_q   <= req_addr_n;
    end
  end

  // A redirect coinciding with the ack retires the outstanding request, so
  // there is nothing left to drop and the FSM returns straight to IDLE.
  always_comb begin
    state_n      = state_q;
    fetch_addr_n = fetch_addr_q;
    req_addr_n   = req_addr_q;
    ack_push     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          fetch_addr_n = redirect_addr;
        end else if (!halt && !fifo_full) begin
          state_n    = ST_WAIT;
          req_addr_n = fetch_addr_q;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          fetch_addr_n = redirect_addr;
          state_n      = imem_ack ? ST_IDLE : ST_DROP;
        end else if (imem_ack) begin
          ack_push     = 1'b1;
          fetch_addr_n = fetch_addr_q + ADDR_W'(1);
          state_n      = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (redirect) fetch_addr_n = redirect_addr;
        if (imem_ack) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign imem_req  = (state_q != ST_IDLE);
  assign imem_addr = req_addr_q;
  assign fifo_pop  = instr_take && fifo_valid && !redirect;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass      = ack_push && !fifo_valid;
  assign memInstr    = bypass ? imem_data : fifo_head;
  assign instr_valid = bypass || fifo_valid;
  assign fifo_push   = ack_push && !(bypass && instr_take);
`else
  assign memInstr    = fifo_head;
  assign instr_valid = fifo_valid;
  assign fifo_push   = ack_push;
`endif

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (Clock),
    .rst       (Reset),
    .push      (fifo_push),
    .push_data (imem_data),
    .pop       (fifo_pop),
    .flush     (redirect),
    .head_data (fifo_head),
    .head_valid(fifo_valid),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: delivered bytes must follow mem[] from the last redirect.
module tb_instr_fetch_queue;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       redirect;
  logic [7:0] redirect_addr;
  logic       halt;
  logic       instr_take;
  logic [7:0] memInstr;
  logic       instr_valid;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;

  always #5 Clock = ~Clock;

  instr_fetch_queue #(
    .DEPTH(4)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .halt         (halt),
    .instr_take   (instr_take),
    .memInstr     (memInstr),
    .instr_valid  (instr_valid),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data)
  );

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [7:0]  rom [256];
  logic [7:0]  sb [$];
  logic [7:0]  req_log [$];
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task tick();
    @(posedge Clock);
    #1;
  endtask

  // Expected stream after (re)start: consecutive bytes of mem from start, wrapping at 0xFF.
  task automatic sb_restart(input logic [7:0] start);
    logic [7:0] p;
    p = start;
    sb.delete();
    for (int i = 0; i < 256; i++) begin
      sb.push_back(rom[p]);
      p++;
    end
  endtask

  task automatic wait_req(input string name, input logic [7:0] a, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (imem_req && imem_addr == a) break;
      tick();
    end
    check(name, {imem_req, imem_addr}, {1'b1, a});
  endtask

  // Memory model: accepts a request, holds for 1..N cycles, then acks one cycle.
  initial begin
    logic [7:0]  a;
    int unsigned lat;
    imem_ack  = 1'b0;
    imem_data = '0;
    forever begin
      @(posedge Clock);
      #1;
      if (imem_req && !Reset) begin
        a = imem_addr;
        req_log.push_back(a);
        lat = $urandom_range(lat_max, lat_min);
        for (int unsigned i = 1; i < lat; i++) begin
          @(posedge Clock);
          #1;
          if (!Reset) check("req_hold", {imem_req, imem_addr}, {1'b1, a});
        end
        imem_ack  = 1'b1;
        imem_data = rom[a];
        @(posedge Clock);
        #1;
        imem_ack  = 1'b0;
        imem_data = 8'($urandom);
      end
    end
  end

  // Monitor: every accepted take must deliver the next expected byte.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge Clock);
      if (Reset !== 1'b1 && instr_take && instr_valid && !redirect) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL sb_underflow: got 0x%0h, expected none queued", memInstr);
        end else begin
          e = sb.pop_front();
          check("take_data", memInstr, e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int highs;
    int since;
    Reset = 1'b1;
    redirect = 1'b0;
    redirect_addr = '0;
    halt = 1'b0;
    instr_take = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    sb_restart(8'h00);
    repeat (2) tick();
    check("rst_valid", instr_valid, 1'b0);
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, 8'h00);
    check("rst_instr", memInstr, 8'h00);

    // Fill to full with single-cycle memory and no takes.
    req_log.delete();
    Reset = 1'b0;
    repeat (20) tick();
    check("fill_nreq", req_log.size(), 4);
    for (int i = 0; i < 4; i++) check("fill_addr", (i < req_log.size()) ? req_log[i] : 8'hxx, 8'(i));
    check("fill_valid", instr_valid, 1'b1);
    check("fill_head", memInstr, rom[0]);
    highs = 0;
    for (int i = 0; i < 5; i++) begin
      if (imem_req) highs++;
      tick();
    end
    check("full_noreq", highs, 0);

    // One pop from full: next head visible, refetch of 0x04 the following cycle.
    instr_take = 1'b1;
    tick();
    instr_take = 1'b0;
    check("pop_head", memInstr, rom[1]);
    check("pop_valid", instr_valid, 1'b1);
    tick();
    check("refetch", {imem_req, imem_addr}, {1'b1, 8'h04});

    // Redirect while 0x05 is outstanding with a 3-cycle ack.
    repeat (4) tick();
    lat_min = 3;
    lat_max = 3;
    instr_take = 1'b1;
    tick();
    instr_take = 1'b0;
    wait_req("req_05", 8'h05, 10);
    tick();
    redirect = 1'b1;
    redirect_addr = 8'h40;
    sb_restart(8'h40);
    tick();
    redirect = 1'b0;
    req_log.delete();
    check("flush_empty", instr_valid, 1'b0);
    check("drop_req", imem_req, 1'b1);
    for (int i = 0; i < 12 && req_log.size() == 0; i++) tick();
    check("redir_addr", (req_log.size() > 0) ? req_log[0] : 8'hxx, 8'h40);
    lat_min = 1;
    lat_max = 1;

    // Address wrap 0xFE -> 0xFF -> 0x00.
    repeat (6) tick();
    redirect = 1'b1;
    redirect_addr = 8'hFE;
    sb_restart(8'hFE);
    instr_take = 1'b1;
    tick();
    redirect = 1'b0;
    req_log.delete();
    repeat (15) tick();
    instr_take = 1'b0;
    check("wrap_n", req_log.size() >= 3, 1'b1);
    for (int i = 0; i < 3; i++) check("wrap_addr", (i < req_log.size()) ? req_log[i] : 8'hxx, 8'(8'hFE + i));

    // Halt with a request outstanding: it completes and pushes, nothing new issues.
    lat_min = 3;
    lat_max = 3;
    redirect = 1'b1;
    redirect_addr = 8'h80;
    sb_restart(8'h80);
    tick();
    redirect = 1'b0;
    wait_req("req_80", 8'h80, 20);
    halt = 1'b1;
    for (int i = 0; i < 10 && imem_req; i++) tick();
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      if (imem_req) highs++;
      tick();
    end
    check("halt_noreq", highs, 0);
    check("halt_valid", instr_valid, 1'b1);
    check("halt_head", memInstr, rom[8'h80]);
    halt = 1'b0;
    lat_min = 1;
    wait_req("unhalt_81", 8'h81, 3);

    // Asynchronous reset mid-fetch clears outputs immediately.
    lat_max = 4;
    instr_take = 1'b1;
    repeat (7) tick();
    #2;
    Reset = 1'b1;
    #1;
    check("arst_valid", instr_valid, 1'b0);
    check("arst_req", imem_req, 1'b0);
    check("arst_addr", imem_addr, 8'h00);
    check("arst_instr", memInstr, 8'h00);
    instr_take = 1'b0;
    repeat (6) tick();
    sb_restart(8'h00);
    Reset = 1'b0;

    // Randomised traffic against the stream model.
    since = 0;
    for (int c = 0; c < 2500; c++) begin
      instr_take = ($urandom_range(3, 0) != 0);
      if ($urandom_range(15, 0) == 0) halt = ~halt;
      if ($urandom_range(40, 0) == 0 || since > 250) begin
        redirect = 1'b1;
        redirect_addr = 8'($urandom);
        sb_restart(redirect_addr);
        since = 0;
      end else begin
        redirect = 1'b0;
      end
      since++;
      tick();
    end
    redirect = 1'b0;
    halt = 1'b0;
    instr_take = 1'b0;
    repeat (8) tick();

`ifdef FETCH_BYPASS_EN
    // Bypass: empty queue, ack with take consumes the byte in the ack cycle.
    lat_min = 2;
    lat_max = 2;
    redirect = 1'b1;
    redirect_addr = 8'h10;
    sb_restart(8'h10);
    tick();
    redirect = 1'b0;
    instr_take = 1'b1;
    wait_req("byp_req", 8'h10, 20);
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      if (imem_ack) break;
    end
    check("byp_valid", instr_valid, 1'b1);
    check("byp_data", memInstr, rom[8'h10]);
    instr_take = 1'b0;
    @(posedge Clock);
    #1;
    check("byp_empty", instr_valid, 1'b0);
    repeat (4) tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
